// File: rtl/fetchflare_req_arbiter.sv
// Purpose : round-robin share of one HPDcache request/response port among prefetch engines.
// Latency : engine handshake in cycle t -> hpdcache_req_valid_o in t+1; responses routed combinationally.
// Backpressure: one-entry output register holds while the cache is not ready; engines see ready=0 then.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   engine_req_valid_i/_o    per-engine request valid / grant (ready), engine_req_i per-engine payload
//   engine_rsp_valid_o       per-engine response strobe, engine_rsp_o response payload (broadcast)
//   engine_idle_o            engine has nothing in flight (counter zero, not sitting in output register)
//   hpdcache_req_*           registered request toward the cache (valid/ready)
//   hpdcache_rsp_*           response from the cache, routed by tid

package fetchflare_pkg;
   localparam int unsigned HPDC_TID_W = 6;
   localparam int unsigned HPDC_SID_W = 3;

   typedef struct packed {
      logic [39:0]             addr;
      logic [3:0]              op;
      logic [2:0]              size;
      logic [HPDC_SID_W-1:0]   sid;
      logic [HPDC_TID_W-1:0]   tid;
      logic                    need_rsp;
   } hpdcache_req_t;

   typedef struct packed {
      logic [63:0]             rdata;
      logic [HPDC_SID_W-1:0]   sid;
      logic [HPDC_TID_W-1:0]   tid;
      logic                    error;
   } hpdcache_rsp_t;
endpackage

module fetchflare_req_arbiter
   import fetchflare_pkg::*;
#(
   parameter int unsigned           NUM_ENGINES       = 4,
   parameter int unsigned           OUTSTANDING_WIDTH = 4,
   parameter logic [HPDC_SID_W-1:0] ARB_SID           = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_ENGINES-1:0]  engine_req_valid_i,
   output logic [NUM_ENGINES-1:0]  engine_req_ready_o,
   input  hpdcache_req_t           engine_req_i [NUM_ENGINES],
   output logic [NUM_ENGINES-1:0]  engine_rsp_valid_o,
   output hpdcache_rsp_t           engine_rsp_o,
   output logic [NUM_ENGINES-1:0]  engine_idle_o,
   output logic                    hpdcache_req_valid_o,
   input  logic                    hpdcache_req_ready_i,
   output hpdcache_req_t           hpdcache_req_o,
   input  logic                    hpdcache_rsp_valid_i,
   input  hpdcache_rsp_t           hpdcache_rsp_i
);

   localparam int unsigned IDX_W  = $clog2(NUM_ENGINES);
   localparam int unsigned CAND_W = IDX_W + 1;
   localparam logic [OUTSTANDING_WIDTH-1:0] CNT_CAP = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   out_state_e                    out_valid_q, out_valid_d;
   hpdcache_req_t                 out_req_q, out_req_d;
   logic [IDX_W-1:0]              rr_q, rr_d;
   logic [OUTSTANDING_WIDTH-1:0]  cnt_q [NUM_ENGINES];
   logic [OUTSTANDING_WIDTH-1:0]  cnt_d [NUM_ENGINES];

   logic                          can_load;
   logic [NUM_ENGINES-1:0]        eligible;
   logic [NUM_ENGINES-1:0]        rsp_hit;
   logic [NUM_ENGINES-1:0]        grant_vec;
   logic                          grant_vld;
   logic [IDX_W-1:0]              grant_idx;
   logic [CAND_W-1:0]             cand;

   // Capped engines drop out of arbitration until a response frees a slot.
   always_comb begin
      can_load = (out_valid_q == EMPTY) || hpdcache_req_ready_i;
      eligible = '0;
      rsp_hit  = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         eligible[i] = engine_req_valid_i[i] && (cnt_q[i] != CNT_CAP);
         // tid values at or above NUM_ENGINES never match, so they are dropped here.
         rsp_hit[i]  = hpdcache_rsp_valid_i && (hpdcache_rsp_i.tid == HPDC_TID_W'(i));
      end
   end

   // Round-robin search starting at rr_q; the candidate wraps by subtraction so
   // non-power-of-two engine counts work without a modulo operator.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned off = 0; off < NUM_ENGINES; off++) begin
         cand = {1'b0, rr_q} + CAND_W'(off);
         if (cand >= CAND_W'(NUM_ENGINES)) begin
            cand = cand - CAND_W'(NUM_ENGINES);
         end
         if (can_load && !grant_vld && eligible[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         grant_vec[i] = grant_vld && (grant_idx == IDX_W'(i));
      end
   end

   // Output register next state and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_req_d   = out_req_q;
      rr_d        = rr_q;
      case (out_valid_q)
         EMPTY: if (grant_vld) out_valid_d = FULL;
         FULL:  if (hpdcache_req_ready_i && !grant_vld) out_valid_d = EMPTY;
      endcase
      if (grant_vld) begin
         out_req_d     = engine_req_i[grant_idx];
         out_req_d.tid = HPDC_TID_W'(grant_idx);
         out_req_d.sid = ARB_SID;
         rr_d          = (grant_idx == IDX_W'(NUM_ENGINES - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Decrement only from a non-zero count so stale responses cannot underflow.
   always_comb begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
         cnt_d[i] = cnt_q[i];
         if (grant_vec[i] && !(rsp_hit[i] && (cnt_q[i] != '0))) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!grant_vec[i] && rsp_hit[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= EMPTY;
         out_req_q   <= '0;
         rr_q        <= '0;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         out_valid_q <= out_valid_d;
         out_req_q   <= out_req_d;
         rr_q        <= rr_d;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // An entry still sitting in the output register counts as in flight.
   always_comb begin
      engine_idle_o = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         engine_idle_o[i] = (cnt_q[i] == '0) &&
                            !((out_valid_q == FULL) && (out_req_q.tid == HPDC_TID_W'(i)));
      end
   end

   assign engine_req_ready_o   = grant_vec;
   assign engine_rsp_valid_o   = rsp_hit;
   assign engine_rsp_o         = hpdcache_rsp_i;
   assign hpdcache_req_valid_o = (out_valid_q == FULL);
   assign hpdcache_req_o       = out_req_q;

endmodule

// File: tb/tb_fetchflare_req_arbiter.sv
// Purpose : directed and randomized checks of fetchflare_req_arbiter against a reference model.
// Latency : inputs change after the falling edge, outputs are compared 1-2 time units later.
// Backpressure: hpdcache_req_ready_i is driven low in directed steps and randomly.
module tb_fetchflare_req_arbiter;
   import fetchflare_pkg::*;

   localparam int N   = 4;
   localparam int OW  = 2;
   localparam int CAP = (1 << OW) - 1;
   localparam logic [2:0] SID = 3'd5;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b1;
   logic [N-1:0]   engine_req_valid_i;
   logic [N-1:0]   engine_req_ready_o;
   hpdcache_req_t  engine_req_i [N];
   logic [N-1:0]   engine_rsp_valid_o;
   hpdcache_rsp_t  engine_rsp_o;
   logic [N-1:0]   engine_idle_o;
   logic           hpdcache_req_valid_o;
   logic           hpdcache_req_ready_i;
   hpdcache_req_t  hpdcache_req_o;
   logic           hpdcache_rsp_valid_i;
   hpdcache_rsp_t  hpdcache_rsp_i;

   fetchflare_req_arbiter #(
      .NUM_ENGINES       (N),
      .OUTSTANDING_WIDTH (OW),
      .ARB_SID           (SID)
   ) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .engine_req_valid_i   (engine_req_valid_i),
      .engine_req_ready_o   (engine_req_ready_o),
      .engine_req_i         (engine_req_i),
      .engine_rsp_valid_o   (engine_rsp_valid_o),
      .engine_rsp_o         (engine_rsp_o),
      .engine_idle_o        (engine_idle_o),
      .hpdcache_req_valid_o (hpdcache_req_valid_o),
      .hpdcache_req_ready_i (hpdcache_req_ready_i),
      .hpdcache_req_o       (hpdcache_req_o),
      .hpdcache_rsp_valid_i (hpdcache_rsp_valid_i),
      .hpdcache_rsp_i       (hpdcache_rsp_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: round-robin pointer, in-flight counts, output slot contents.
   int            m_rr;
   int            m_cnt [N];
   bit            m_full;
   hpdcache_req_t m_req;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rr   = 0;
      m_full = 1'b0;
      m_req  = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   function automatic int pick_winner();
      if (m_full && !hpdcache_req_ready_i) return -1;
      for (int k = 0; k < N; k++) begin
         int e = (m_rr + k) % N;
         if (engine_req_valid_i[e] && m_cnt[e] < CAP) return e;
      end
      return -1;
   endfunction

   task automatic check_all();
      int           w;
      logic [N-1:0] exp_rdy, exp_rsp, exp_idle;
      w = pick_winner();
      exp_rdy  = '0;
      exp_rsp  = '0;
      exp_idle = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      for (int k = 0; k < N; k++) begin
         exp_rsp[k]  = hpdcache_rsp_valid_i && (int'(hpdcache_rsp_i.tid) == k);
         exp_idle[k] = (m_cnt[k] == 0) && !(m_full && int'(m_req.tid) == k);
      end
      check("ready", engine_req_ready_o, exp_rdy);
      check("rsp_strobe", engine_rsp_valid_o, exp_rsp);
      check("rsp_payload", engine_rsp_o, hpdcache_rsp_i);
      check("idle", engine_idle_o, exp_idle);
      check("req_valid", hpdcache_req_valid_o, m_full);
      check("req_payload", hpdcache_req_o, m_req);
   endtask

   task automatic model_step();
      int w;
      w = pick_winner();
      for (int k = 0; k < N; k++) begin
         int inc = (w == k) ? 1 : 0;
         int dec = (hpdcache_rsp_valid_i && int'(hpdcache_rsp_i.tid) == k && m_cnt[k] > 0) ? 1 : 0;
         m_cnt[k] = m_cnt[k] + inc - dec;
      end
      if (w >= 0) begin
         m_req     = engine_req_i[w];
         m_req.tid = 6'(w);
         m_req.sid = SID;
         m_full    = 1'b1;
         m_rr      = (w + 1) % N;
      end else if (hpdcache_req_ready_i) begin
         m_full = 1'b0;
      end
   endtask

   // Called just after a falling edge with inputs set; ends at the next falling edge.
   task automatic cycle();
      #1;
      check_all();
      model_step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic rand_payloads();
      logic [63:0] r;
      for (int k = 0; k < N; k++) begin
         r = {$urandom(), $urandom()};
         engine_req_i[k] = r[$bits(hpdcache_req_t)-1:0];
      end
   endtask

   task automatic set_idle();
      engine_req_valid_i   = '0;
      hpdcache_req_ready_i = 1'b1;
      hpdcache_rsp_valid_i = 1'b0;
      hpdcache_rsp_i       = '0;
      rand_payloads();
   endtask

   task automatic set_rsp(input int tid);
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      hpdcache_rsp_i       = r[$bits(hpdcache_rsp_t)-1:0];
      hpdcache_rsp_i.tid   = 6'(tid);
      hpdcache_rsp_valid_i = 1'b1;
   endtask

   task automatic drain();
      set_idle();
      for (int k = 0; k < N; k++) begin
         while (m_cnt[k] > 0) begin
            set_rsp(k);
            cycle();
         end
      end
      set_idle();
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] rr_order [8];

      // Reset state
      set_idle();
      model_reset();
      #1 rst_ni = 1'b0;
      #2;
      check("rst_req_valid", hpdcache_req_valid_o, 1'b0);
      check("rst_req_payload", hpdcache_req_o, '0);
      check("rst_ready", engine_req_ready_o, 4'b0000);
      check("rst_idle", engine_idle_o, 4'b1111);
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle();
      cycle();

      // Single engine: request, one-cycle latency, tid/sid stamping, response routing
      engine_req_valid_i = 4'b0100;
      #1 check("t1_ready", engine_req_ready_o, 4'b0100);
      cycle();
      set_idle();
      #1;
      check("t1_valid", hpdcache_req_valid_o, 1'b1);
      check("t1_tid", hpdcache_req_o.tid, 6'd2);
      check("t1_sid", hpdcache_req_o.sid, SID);
      check("t1_idle_busy", engine_idle_o, 4'b1011);
      cycle();
      set_rsp(2);
      #1 check("t1_rsp_strobe", engine_rsp_valid_o, 4'b0100);
      cycle();
      set_idle();
      #1 check("t1_idle_back", engine_idle_o, 4'b1111);
      cycle();

      // All engines valid: pointer sits at 3, so the order wraps 3,0,1,2,...
      rr_order = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      for (int c = 0; c < 8; c++) begin
         rand_payloads();
         engine_req_valid_i = 4'b1111;
         #1 check("rr_order", engine_req_ready_o, rr_order[c]);
         if (c > 0) check("rr_throughput", hpdcache_req_valid_o, 1'b1);
         cycle();
      end
      drain();

      // Back-pressure: output held for 5 cycles, then drain and load together
      engine_req_valid_i = 4'b0001;
      #1 check("bp_first", engine_req_ready_o, 4'b0001);
      cycle();
      for (int c = 0; c < 5; c++) begin
         rand_payloads();
         engine_req_valid_i   = 4'b1111;
         hpdcache_req_ready_i = 1'b0;
         #1;
         check("bp_ready_low", engine_req_ready_o, 4'b0000);
         check("bp_valid_held", hpdcache_req_valid_o, 1'b1);
         check("bp_tid_held", hpdcache_req_o.tid, 6'd0);
         cycle();
      end
      rand_payloads();
      hpdcache_req_ready_i = 1'b1;
      #1 check("bp_reload", engine_req_ready_o, 4'b0010);
      cycle();
      set_idle();
      #1 check("bp_new_tid", hpdcache_req_o.tid, 6'd1);
      cycle();
      drain();

      // Counter cap at 3: engine 0 saturates, engine 1 proceeds, one response reopens engine 0
      for (int c = 0; c < 3; c++) begin
         rand_payloads();
         engine_req_valid_i = 4'b0001;
         cycle();
      end
      engine_req_valid_i = 4'b0011;
      #1 check("cap_skip", engine_req_ready_o, 4'b0010);
      cycle();
      set_idle();
      engine_req_valid_i = 4'b0001;
      set_rsp(0);
      #1 check("cap_still_full", engine_req_ready_o, 4'b0000);
      cycle();
      set_idle();
      engine_req_valid_i = 4'b0001;
      #1 check("cap_reopen", engine_req_ready_o, 4'b0001);
      cycle();
      drain();

      // Grant and response to engine 1 in the same cycle
      engine_req_valid_i = 4'b0010;
      cycle();
      rand_payloads();
      set_rsp(1);
      cycle();
      set_idle();
      cycle();
      #1 check("sim_cnt_kept", engine_idle_o[1], 1'b0);
      set_rsp(1);
      cycle();
      set_idle();
      #1 check("sim_cnt_zero", engine_idle_o[1], 1'b1);
      cycle();
      // Out-of-range tid and response at zero count
      set_rsp(7);
      #1 check("tid7_no_strobe", engine_rsp_valid_o, 4'b0000);
      cycle();
      set_rsp(0);
      cycle();
      set_idle();
      #1 check("no_underflow", engine_idle_o, 4'b1111);
      cycle();

      // Reset while FULL with two requests in flight for engine 3
      engine_req_valid_i = 4'b1000;
      cycle();
      rand_payloads();
      cycle();
      set_idle();
      hpdcache_req_ready_i = 1'b0;
      #2 rst_ni = 1'b0;
      model_reset();
      #1;
      check("mid_rst_valid", hpdcache_req_valid_o, 1'b0);
      check("mid_rst_idle", engine_idle_o, 4'b1111);
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;
      hpdcache_req_ready_i = 1'b1;
      engine_req_valid_i = 4'b1111;
      #1 check("mid_rst_rr", engine_req_ready_o, 4'b0001);
      cycle();
      drain();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         rand_payloads();
         engine_req_valid_i   = 4'($urandom());
         hpdcache_req_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) set_rsp(int'($urandom_range(0, 7)));
         else hpdcache_rsp_valid_i = 1'b0;
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetchflare_req_arbiter.md
# fetchflare_req_arbiter

Shares the single HPDcache request/response port among NUM_ENGINES fetchflare prefetch engines. Requests are granted round-robin into a registered output stage, with the engine index stamped into the request TID. Responses are routed back to the issuing engine by TID. Per-engine outstanding counters cap each engine's in-flight requests and report when an engine has fully drained.

## Interface
Parameters:
- NUM_ENGINES, default 4: number of requesting engines, 2..8.
- OUTSTANDING_WIDTH, default 4: width of each per-engine outstanding counter; the cap is 2^OUTSTANDING_WIDTH-1.
- ARB_SID, default 0: value driven on hpdcache_req_o.sid.

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- engine_req_valid_i  in  NUM_ENGINES  per-engine request valid.
- engine_req_ready_o  out  NUM_ENGINES  per-engine grant; a handshake occurs when valid and ready are both high.
- engine_req_i  in  NUM_ENGINES x hpdcache_req_t  per-engine request payload.
- engine_rsp_valid_o  out  NUM_ENGINES  per-engine response strobe.
- engine_rsp_o  out  hpdcache_rsp_t  response payload, broadcast to all engines.
- engine_idle_o  out  NUM_ENGINES  high when the engine has no outstanding requests.
- hpdcache_req_valid_o  out  1  request valid toward the cache.
- hpdcache_req_ready_i  in  1  cache accepts the request.
- hpdcache_req_o  out  hpdcache_req_t  registered request payload.
- hpdcache_rsp_valid_i  in  1  cache response valid.
- hpdcache_rsp_i  in  hpdcache_rsp_t  cache response.

## Operation
Output stage: a one-entry register with valid bit out_valid_q.
- Two states:
  - EMPTY: out_valid_q=0.
  - FULL: out_valid_q=1, which drives hpdcache_req_valid_o.
- The register can load when it is EMPTY, or when it is FULL and hpdcache_req_ready_i=1 (drain and load in the same cycle).
- FULL → EMPTY: drain with no new grant.
- EMPTY → FULL: a grant occurs.
- FULL → FULL: drain and grant in the same cycle, or hpdcache_req_ready_i=0.
- While FULL and not ready, the payload and valid are held stable.

Arbitration:
- An engine is eligible when engine_req_valid_i[i]=1 and cnt[i] is not equal to the cap.
- When the register can load, the winner is the first eligible index searching from rr_q, wrapping modulo NUM_ENGINES.
- Only the winner gets engine_req_ready_o[i]=1. All other ready bits are 0.
- engine_req_ready_o is combinational from the inputs and state; it never depends on engine_req_ready_o itself.
- On a grant to engine i: rr_q ← (i+1) mod NUM_ENGINES. With no grant, rr_q holds.
- The captured payload equals engine_req_i[i], except:
  - tid = i, zero-extended;
  - sid = ARB_SID.
- Arbitration does not look at the payload.

Outstanding counters cnt[i], each OUTSTANDING_WIDTH bits:
- Increment on a grant to engine i.
- Decrement on a routed response to engine i, only when cnt[i] > 0. A decrement at 0 is ignored, with no underflow.
- Simultaneous increment and decrement leave cnt[i] unchanged.
- engine_idle_o[i] = (cnt[i]==0) and the output register does not hold an entry with tid==i.

Response routing:
- engine_rsp_valid_o[k] = hpdcache_rsp_valid_i and (hpdcache_rsp_i.tid == k). This is combinational.
- engine_rsp_o = hpdcache_rsp_i.
- Responses with tid ≥ NUM_ENGINES are dropped: no strobe and no counter change.

## Timing
- Reset values:
  - hpdcache_req_valid_o=0;
  - hpdcache_req_o=0;
  - engine_req_ready_o=0, because the register is EMPTY but no engine is valid;
  - engine_rsp_valid_o=0 unless a response arrives;
  - engine_idle_o all 1;
  - rr_q=0;
  - all cnt=0.
- Latency: an engine handshake in cycle t gives hpdcache_req_valid_o=1 in cycle t+1.
- Throughput: one request per cycle while hpdcache_req_ready_i=1.
- Response path has zero latency. The counter update is visible on engine_idle_o the next cycle.
- A grant and a response to the same engine in the same cycle leave the count unchanged.
- Starvation bound: a continuously eligible engine is granted within NUM_ENGINES load opportunities.
- Reset asserted mid-transfer clears the output register immediately. Lost in-flight responses are the system's concern; after reset, stale responses still strobe but cannot underflow the counters.

## Test plan
- Single engine, ready=1: engine 2 sends one request at cycle 5 → hpdcache_req_valid_o at cycle 6 with tid=2 and sid=ARB_SID. A response with tid=2 → engine_rsp_valid_o=0b0100, and engine_idle_o[2] returns to 1.
- All 4 engines valid continuously, ready=1: grant order 0,1,2,3,0,…, one request per cycle, rr_q wraps from 3 to 0.
- Back-pressure: ready=0 for 5 cycles while FULL → payload and valid are stable; engine_req_ready_o=0b0000. When ready rises, drain and a new load happen in the same cycle.
- Cap, OUTSTANDING_WIDTH=2: engine 0 issues 3 requests with no responses → engine 0 is no longer granted and engine 1 proceeds. One response with tid=0 → engine 0 is eligible again next cycle.
- Simultaneous events: a grant to engine 1 and a response with tid=1 in the same cycle → cnt[1] unchanged. A response with tid=7 (NUM_ENGINES=4) → no strobe and no counter change. A response with tid=0 while cnt[0]=0 → cnt stays 0.
- Reset while FULL with cnt[3]=2 → next cycle hpdcache_req_valid_o=0, engine_idle_o=0b1111, rr_q=0.
